// File: rtl/axis_demux_task_create_ack.sv
// AXI-Stream 1:2 demux for task-create-ack beats: 2-entry input FIFO, one output register per master.
// Optional per-master transfer counters are enabled by AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN.
module axis_demux_task_create_ack #(
  parameter  int DEST_WIDTH = 8,
  parameter  int ROUTE_BIT  = 0,
  localparam int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S00_AXIS_tvalid,
  output logic                  S00_AXIS_tready,
  input  logic [DATA_WIDTH-1:0] S00_AXIS_tdata,
  input  logic [DEST_WIDTH-1:0] S00_AXIS_tdest,
  output logic                  M00_AXIS_tvalid,
  input  logic                  M00_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M00_AXIS_tdata,
  output logic [DEST_WIDTH-1:0] M00_AXIS_tdest,
  output logic                  M01_AXIS_tvalid,
  input  logic                  M01_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M01_AXIS_tdata,
  output logic [DEST_WIDTH-1:0] M01_AXIS_tdest
`ifdef AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN
  ,
  output logic [31:0]           M00_beat_count,
  output logic [31:0]           M01_beat_count
`endif
);

  logic [DATA_WIDTH-1:0] fifo_data_p0 [2];
  logic [DEST_WIDTH-1:0] fifo_dest_p0 [2];
  logic                  wr_ptr_p0;
  logic                  rd_ptr_p0;
  logic [1:0]            count_p0;
  logic [1:0]            count_next;
  logic                  ready_p0;

  logic                  m0_vld_p1;
  logic [DATA_WIDTH-1:0] m0_data_p1;
  logic [DEST_WIDTH-1:0] m0_dest_p1;
  logic                  m1_vld_p1;
  logic [DATA_WIDTH-1:0] m1_data_p1;
  logic [DEST_WIDTH-1:0] m1_dest_p1;

  logic push;
  logic pop;
  logic head_sel;
  logic m0_done;
  logic m1_done;
  logic m0_free;
  logic m1_free;

  assign push     = S00_AXIS_tvalid & ready_p0;
  assign head_sel = fifo_dest_p0[rd_ptr_p0][ROUTE_BIT];
  assign m0_done  = m0_vld_p1 & M00_AXIS_tready;
  assign m1_done  = m1_vld_p1 & M01_AXIS_tready;
  assign m0_free  = ~m0_vld_p1 | M00_AXIS_tready;
  assign m1_free  = ~m1_vld_p1 | M01_AXIS_tready;
  // The head only leaves when its own target can take it, so a stalled target blocks everything behind it.
  assign pop      = (count_p0 != 2'd0) & (head_sel ? m1_free : m0_free);

  always_comb begin
    count_next = count_p0;
    case ({push, pop})
      2'b10:   count_next = count_p0 + 2'd1;
      2'b01:   count_next = count_p0 - 2'd1;
      default: count_next = count_p0;
    endcase
  end

  // Stage p0: input FIFO control and registered slave ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p0  <= 2'd0;
      wr_ptr_p0 <= 1'b0;
      rd_ptr_p0 <= 1'b0;
      ready_p0  <= 1'b0;
    end else begin
      count_p0 <= count_next;
      ready_p0 <= (count_next < 2'd2);
      if (push) wr_ptr_p0 <= ~wr_ptr_p0;
      if (pop)  rd_ptr_p0 <= ~rd_ptr_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_p0[wr_ptr_p0] <= S00_AXIS_tdata;
      fifo_dest_p0[wr_ptr_p0] <= S00_AXIS_tdest;
    end
  end

  // Stage p1: per-master output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_vld_p1 <= 1'b0;
      m1_vld_p1 <= 1'b0;
    end else begin
      if (pop && !head_sel)  m0_vld_p1 <= 1'b1;
      else if (m0_done)      m0_vld_p1 <= 1'b0;
      if (pop && head_sel)   m1_vld_p1 <= 1'b1;
      else if (m1_done)      m1_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && !head_sel) begin
      m0_data_p1 <= fifo_data_p0[rd_ptr_p0];
      m0_dest_p1 <= fifo_dest_p0[rd_ptr_p0];
    end
    if (pop && head_sel) begin
      m1_data_p1 <= fifo_data_p0[rd_ptr_p0];
      m1_dest_p1 <= fifo_dest_p0[rd_ptr_p0];
    end
  end

  assign S00_AXIS_tready = ready_p0;
  assign M00_AXIS_tvalid = m0_vld_p1;
  assign M00_AXIS_tdata  = m0_data_p1;
  assign M00_AXIS_tdest  = m0_dest_p1;
  assign M01_AXIS_tvalid = m1_vld_p1;
  assign M01_AXIS_tdata  = m1_data_p1;
  assign M01_AXIS_tdest  = m1_dest_p1;

`ifdef AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN
  logic [31:0] m0_cnt;
  logic [31:0] m1_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_cnt <= 32'd0;
      m1_cnt <= 32'd0;
    end else begin
      if (m0_done) m0_cnt <= m0_cnt + 32'd1;
      if (m1_done) m1_cnt <= m1_cnt + 32'd1;
    end
  end

  assign M00_beat_count = m0_cnt;
  assign M01_beat_count = m1_cnt;
`endif

endmodule

// File: tb/tb_axis_demux_task_create_ack.sv
// Bench for axis_demux_task_create_ack: directed vector table, corner sequences, and randomized
// traffic checked against per-output expected-beat queues. Honours AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN.
module tb_axis_demux_task_create_ack;

  localparam int DW = 8;
  localparam int RB = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv;
  logic        sr;
  logic [63:0] sd;
  logic [7:0]  sdst;
  logic        v0, r0, v1, r1;
  logic [63:0] d0, d1;
  logic [7:0]  t0, t1;
`ifdef AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN
  logic [31:0] cnt0, cnt1;
`endif

  int n_vec  = 0;
  int n_err  = 0;
  int dlv0   = 0;
  int dlv1   = 0;

  logic [71:0] q0 [$];
  logic [71:0] q1 [$];

  always #5 clk = ~clk;

  axis_demux_task_create_ack #(.DEST_WIDTH(DW), .ROUTE_BIT(RB)) dut (
    .clk(clk), .rst(rst),
    .S00_AXIS_tvalid(sv), .S00_AXIS_tready(sr), .S00_AXIS_tdata(sd), .S00_AXIS_tdest(sdst),
    .M00_AXIS_tvalid(v0), .M00_AXIS_tready(r0), .M00_AXIS_tdata(d0), .M00_AXIS_tdest(t0),
    .M01_AXIS_tvalid(v1), .M01_AXIS_tready(r1), .M01_AXIS_tdata(d1), .M01_AXIS_tdest(t1)
`ifdef AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN
    , .M00_beat_count(cnt0), .M01_beat_count(cnt1)
`endif
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every accepted beat is queued for the output its routing bit names;
  // every completed master transfer must match the oldest queued beat for that output.
  logic        stall0, stall1;
  logic [71:0] hold0, hold1;
  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      stall0 = 1'b0; stall1 = 1'b0;
      dlv0 = 0; dlv1 = 0;
    end else begin
      if (sv && sr) begin
        if (sdst[RB]) q1.push_back({sdst, sd});
        else          q0.push_back({sdst, sd});
      end
      if (stall0) chk("m0_stable", {7'd0, v0, t0, d0}, {7'd0, 1'b1, hold0});
      if (stall1) chk("m1_stable", {7'd0, v1, t1, d1}, {7'd0, 1'b1, hold1});
      if (v0 && r0) begin
        if (q0.size() == 0) chk("m0_unexpected", {t0, d0}, 72'd0);
        else chk("m0_beat", {t0, d0}, q0.pop_front());
        dlv0++;
      end
      if (v1 && r1) begin
        if (q1.size() == 0) chk("m1_unexpected", {t1, d1}, 72'd0);
        else chk("m1_beat", {t1, d1}, q1.pop_front());
        dlv1++;
      end
      stall0 = v0 && !r0; hold0 = {t0, d0};
      stall1 = v1 && !r1; hold1 = {t1, d1};
    end
  end

  typedef struct {
    logic        sv;
    logic [63:0] data;
    logic [7:0]  dest;
    logic        r0, r1;
    logic        e_sr, e_v0, e_v1;
    logic [71:0] e_out;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [63:0] dt, input logic [7:0] ds,
                              input logic a, input logic b, input logic esr, input logic ev0,
                              input logic ev1, input logic [71:0] eo);
    vec_t v;
    v.sv = s; v.data = dt; v.dest = ds; v.r0 = a; v.r1 = b;
    v.e_sr = esr; v.e_v0 = ev0; v.e_v1 = ev1; v.e_out = eo;
    return v;
  endfunction

  task automatic send(input logic [63:0] dt, input logic [7:0] ds);
    logic acc;
    bit   done;
    done = 0;
    sv = 1'b1; sd = dt; sdst = ds;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = sr;
      tick();
      if (acc) done = 1;
    end
    if (!done) chk("send_timeout", 72'd0, 72'd1);
    sv = 1'b0;
  endtask

  vec_t vt [11];

  initial begin
    int s0, s1;
    bit seen;
    logic [63:0] a1, a2, a3, a4;
    a1 = 64'hA1A1_0000_0000_0001; a2 = 64'hA2A2_0000_0000_0002;
    a3 = 64'hA3A3_0000_0000_0003; a4 = 64'hA4A4_0000_0000_0004;
    vt[0]  = mk(0, 64'd0, 8'h00, 1, 1, 1, 0, 0, 72'd0);
    vt[1]  = mk(1, 64'h0123456789ABCDEF, 8'h02, 1, 1, 1, 0, 0, 72'd0);
    vt[2]  = mk(0, 64'd0, 8'h00, 1, 1, 1, 1, 0, {8'h02, 64'h0123456789ABCDEF});
    vt[3]  = mk(0, 64'd0, 8'h00, 1, 1, 1, 0, 0, 72'd0);
    vt[4]  = mk(1, a1, 8'h01, 1, 0, 1, 0, 0, 72'd0);
    vt[5]  = mk(1, a2, 8'h01, 1, 0, 1, 0, 1, {8'h01, a1});
    vt[6]  = mk(1, a3, 8'h01, 1, 0, 0, 0, 1, {8'h01, a1});
    vt[7]  = mk(1, a4, 8'h01, 1, 0, 0, 0, 1, {8'h01, a1});
    vt[8]  = mk(0, 64'd0, 8'h00, 1, 1, 1, 0, 1, {8'h01, a2});
    vt[9]  = mk(0, 64'd0, 8'h00, 1, 1, 1, 0, 1, {8'h01, a3});
    vt[10] = mk(0, 64'd0, 8'h00, 1, 1, 1, 0, 0, 72'd0);

    rst = 1'b1; sv = 1'b0; sd = '0; sdst = '0; r0 = 1'b1; r1 = 1'b1;
    repeat (3) tick();
    chk("rst_sready", {71'd0, sr}, 72'd0);
    chk("rst_v0", {71'd0, v0}, 72'd0);
    chk("rst_v1", {71'd0, v1}, 72'd0);
    rst = 1'b0;

    // single beat then M01 backpressure and release
    foreach (vt[i]) begin
      sv = vt[i].sv; sd = vt[i].data; sdst = vt[i].dest; r0 = vt[i].r0; r1 = vt[i].r1;
      tick();
      chk($sformatf("vec%0d_sready", i), {71'd0, sr}, {71'd0, vt[i].e_sr});
      chk($sformatf("vec%0d_v0", i), {71'd0, v0}, {71'd0, vt[i].e_v0});
      chk($sformatf("vec%0d_v1", i), {71'd0, v1}, {71'd0, vt[i].e_v1});
      if (vt[i].e_v0) chk($sformatf("vec%0d_m0", i), {t0, d0}, vt[i].e_out);
      if (vt[i].e_v1) chk($sformatf("vec%0d_m1", i), {t1, d1}, vt[i].e_out);
    end
    sv = 1'b0;

    // streaming, alternating destinations
    s0 = dlv0; s1 = dlv1;
    r0 = 1'b1; r1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sv = 1'b1; sd = {$urandom, $urandom}; sdst = 8'(i % 2);
      tick();
      chk("stream_sready", {71'd0, sr}, 72'd1);
    end
    sv = 1'b0;
    repeat (4) tick();
    chk("stream_m0_count", 72'(dlv0 - s0), 72'd8);
    chk("stream_m1_count", 72'(dlv1 - s1), 72'd8);

    // head-of-line blocking
    r0 = 1'b0; r1 = 1'b1;
    send(64'hB1, 8'h00);
    send(64'hB2, 8'h00);
    send(64'hB3, 8'h01);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hol_m1_blocked", {71'd0, v1}, 72'd0);
    end
    r0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (v1) seen = 1;
    end
    chk("hol_m1_after_drain", {71'd0, seen}, 72'd1);
    repeat (3) tick();

    // reset with beats buffered
    r0 = 1'b0;
    send(64'hC1, 8'h00);
    send(64'hC2, 8'h00);
    send(64'hC3, 8'h00);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_sready", {71'd0, sr}, 72'd0);
    chk("midrst_v0", {71'd0, v0}, 72'd0);
    chk("midrst_v1", {71'd0, v1}, 72'd0);
    tick(); tick();
    rst = 1'b0; r0 = 1'b1; r1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("postrst_idle", {70'd0, v0, v1}, 72'd0);
    end
    chk("postrst_sready", {71'd0, sr}, 72'd1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sv   = ($urandom_range(0, 3) != 0);
      sd   = {$urandom, $urandom};
      sdst = 8'($urandom);
      r0   = ($urandom_range(0, 3) != 0);
      r1   = ($urandom_range(0, 2) != 0);
      tick();
    end
    sv = 1'b0; r0 = 1'b1; r1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (q0.size() == 0 && q1.size() == 0 && !v0 && !v1) seen = 1;
    end
    chk("drain_complete", {71'd0, seen}, 72'd1);

`ifdef AXIS_DEMUX_TASK_CREATE_ACK_STATS_EN
    chk("stats_m0", {40'd0, cnt0}, 72'(dlv0));
    chk("stats_m1", {40'd0, cnt1}, 72'(dlv1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
